// File: rtl/cfu_seq_pkg.sv
// rtl/cfu_seq_pkg.sv - shared widths, control-field layout and state encoding for cfu_seq
package cfu_seq_pkg;

    localparam int XLEN            = 32;
    localparam int CFU_CTRL_WIDTH  = 11;
    localparam int CFU_CTRL_IS_CFU = 0;

    typedef enum logic [1:0] {
        CFU_SEQ_IDLE = 2'd0,
        CFU_SEQ_WAIT = 2'd1,
        CFU_SEQ_DONE = 2'd2
    } cfu_seq_state_t;

    localparam logic [XLEN-1:0] CFU_SEQ_TIMEOUT_VAL = 32'hDEADBEEF;

endpackage

// File: rtl/cfu_seq_watchdog.sv
// rtl/cfu_seq_watchdog.sv - WAIT-cycle counter that flags a unit that never acknowledges
module cfu_seq_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LIMIT) + 1;

    logic          running;
    logic [CW-1:0] count;

    // count holds the index of the current WAIT cycle, so expiry lands on the LIMIT-th one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
        end else if (clear) begin
            running <= 1'b0;
        end else if (running) begin
            count <= count + 1'b1;
        end
    end

    assign expired = running && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/cfu_seq.sv
// rtl/cfu_seq.sv - CFU issue/stall sequencer; optional watchdog under CFU_SEQ_TIMEOUT_EN
module cfu_seq
    import cfu_seq_pkg::*;
#(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    input  logic                      valid_i,
    input  logic [CFU_CTRL_WIDTH-1:0] cfu_ctrl_i,
    input  logic [XLEN-1:0]           src1_i,
    input  logic [XLEN-1:0]           src2_i,
    output logic                      stall_o,
    output logic [XLEN-1:0]           rslt_o,
    output logic [NUM_UNITS-1:0]      req_o,
    output logic [6:0]                funct7_o,
    output logic [XLEN-1:0]           op1_o,
    output logic [XLEN-1:0]           op2_o,
    input  logic [NUM_UNITS-1:0]      ack_i,
    input  logic [NUM_UNITS*XLEN-1:0] urslt_i,
    output logic                      err_o
);

    cfu_seq_state_t  state;
    logic            cmd;
    logic            legal;
    logic            accept;
    logic            ack_hit;
    logic            expired;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ack_rslt;

    assign funct3  = cfu_ctrl_i[3:1];
    assign cmd     = valid_i & cfu_ctrl_i[CFU_CTRL_IS_CFU];
    assign legal   = int'(funct3) < NUM_UNITS;
    assign accept  = cmd && legal && (state == CFU_SEQ_IDLE);
    assign stall_o = accept || (state == CFU_SEQ_WAIT);

    // req_o is one-hot on the selected unit while waiting, so masking ack_i with it drops stray acks
    assign ack_hit = |(ack_i & req_o);

    always_comb begin
        ack_rslt = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (req_o[k]) begin
                ack_rslt = urslt_i[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= CFU_SEQ_IDLE;
            req_o    <= '0;
            rslt_o   <= '0;
            funct7_o <= '0;
            op1_o    <= '0;
            op2_o    <= '0;
        end else begin
            case (state)
                CFU_SEQ_IDLE: begin
                    if (accept) begin
                        funct7_o <= cfu_ctrl_i[10:4];
                        op1_o    <= src1_i;
                        op2_o    <= src2_i;
                        req_o    <= NUM_UNITS'(1) << funct3;
                        state    <= CFU_SEQ_WAIT;
                    end
                end
                CFU_SEQ_WAIT: begin
                    if (ack_hit) begin
                        rslt_o <= ack_rslt;
                        req_o  <= '0;
                        state  <= CFU_SEQ_DONE;
                    end else if (expired) begin
                        rslt_o <= CFU_SEQ_TIMEOUT_VAL;
                        req_o  <= '0;
                        state  <= CFU_SEQ_DONE;
                    end
                end
                CFU_SEQ_DONE: begin
                    // rslt_o doubles as the held result, so it is cleared on the way out
                    if (!stall_i) begin
                        rslt_o <= '0;
                        state  <= CFU_SEQ_IDLE;
                    end
                end
                default: begin
                    req_o  <= '0;
                    rslt_o <= '0;
                    state  <= CFU_SEQ_IDLE;
                end
            endcase
        end
    end

`ifdef CFU_SEQ_TIMEOUT_EN
    logic leave_wait;
    logic err_q;

    assign leave_wait = (state == CFU_SEQ_WAIT) && (ack_hit || expired);

    cfu_seq_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (accept),
        .clear  (leave_wait),
        .expired(expired)
    );

    // an ack in the expiry cycle takes priority, so only a genuine miss sets the flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((state == CFU_SEQ_WAIT) && expired && !ack_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign err_o          = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_cfu_seq.sv
// tb/tb_cfu_seq.sv - randomized self-checking bench for cfu_seq
module tb_cfu_seq;
    import cfu_seq_pkg::*;

    localparam int NU  = 4;
    localparam int TMO = 8;

    logic                      clk;
    logic                      rst_ni;
    logic                      stall_i;
    logic                      valid_i;
    logic [CFU_CTRL_WIDTH-1:0] cfu_ctrl_i;
    logic [XLEN-1:0]           src1_i;
    logic [XLEN-1:0]           src2_i;
    logic                      stall_o;
    logic [XLEN-1:0]           rslt_o;
    logic [NU-1:0]             req_o;
    logic [6:0]                funct7_o;
    logic [XLEN-1:0]           op1_o;
    logic [XLEN-1:0]           op2_o;
    logic [NU-1:0]             ack_i;
    logic [NU*XLEN-1:0]        urslt_i;
    logic                      err_o;

    int   n_tests;
    int   n_fail;
    logic exp_err;

    cfu_seq #(
        .NUM_UNITS     (NU),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .stall_i   (stall_i),
        .valid_i   (valid_i),
        .cfu_ctrl_i(cfu_ctrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .stall_o   (stall_o),
        .rslt_o    (rslt_o),
        .req_o     (req_o),
        .funct7_o  (funct7_o),
        .op1_o     (op1_o),
        .op2_o     (op2_o),
        .ack_i     (ack_i),
        .urslt_i   (urslt_i),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NU*XLEN-1:0] rand_rslts();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One command: accept cycle, j WAIT cycles (ack in the j-th), then h+1 DONE cycles.
    task automatic run_cmd(input int u, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] f7, input int j, input logic [31:0] val,
                           input int h, input logic [NU-1:0] noise);
        logic [NU-1:0] sel;
        int            stalls;
        int            reqs;
        int            rslts;
        sel    = NU'(1) << u;
        stalls = 0;
        reqs   = 0;
        rslts  = 0;
        @(negedge clk);
        valid_i    = 1'b1;
        cfu_ctrl_i = {f7, 3'(u), 1'b1};
        src1_i     = a;
        src2_i     = b;
        ack_i      = noise & ~sel;
        stall_i    = 1'($urandom_range(0, 1));
        urslt_i    = rand_rslts();
        #1;
        if (stall_o) stalls++;
        n_tests++;
        if ({stall_o, req_o, rslt_o, err_o} !== {1'b1, NU'(0), 32'h0, exp_err}) begin
            n_fail++;
            $display("FAIL accept u=%0d: got stall=%0b req=%b rslt=%h err=%0b want stall=1 req=0 rslt=0 err=%0b",
                     u, stall_o, req_o, rslt_o, err_o, exp_err);
        end
        for (int i = 1; i <= j; i++) begin
            @(negedge clk);
            src1_i  = $urandom;
            src2_i  = $urandom;
            stall_i = 1'($urandom_range(0, 1));
            ack_i   = (noise & ~sel) | ((i == j) ? sel : NU'(0));
            urslt_i = rand_rslts();
            if (i == j) urslt_i[u*XLEN +: XLEN] = val;
            #1;
            if (stall_o) stalls++;
            if (req_o != 0) reqs++;
            n_tests++;
            if ({stall_o, req_o, rslt_o, err_o} !== {1'b1, sel, 32'h0, exp_err}) begin
                n_fail++;
                $display("FAIL wait u=%0d cyc=%0d: got stall=%0b req=%b rslt=%h err=%0b want stall=1 req=%b rslt=0 err=%0b",
                         u, i, stall_o, req_o, rslt_o, err_o, sel, exp_err);
            end
            n_tests++;
            if ({funct7_o, op1_o, op2_o} !== {f7, a, b}) begin
                n_fail++;
                $display("FAIL latch u=%0d cyc=%0d: got f7=%h op1=%h op2=%h want f7=%h op1=%h op2=%h",
                         u, i, funct7_o, op1_o, op2_o, f7, a, b);
            end
        end
        for (int k = 0; k <= h; k++) begin
            @(negedge clk);
            ack_i   = noise;
            stall_i = (k < h);
            urslt_i = rand_rslts();
            #1;
            if (stall_o) stalls++;
            if (req_o != 0) reqs++;
            if (rslt_o === val) rslts++;
            n_tests++;
            if ({stall_o, req_o, rslt_o, err_o} !== {1'b0, NU'(0), val, exp_err}) begin
                n_fail++;
                $display("FAIL done u=%0d cyc=%0d: got stall=%0b req=%b rslt=%h err=%0b want stall=0 req=0 rslt=%h err=%0b",
                         u, k, stall_o, req_o, rslt_o, err_o, val, exp_err);
            end
        end
        n_tests++;
        if (stalls != j + 1 || reqs != j || rslts != h + 1) begin
            n_fail++;
            $display("FAIL totals u=%0d: got stalls=%0d reqs=%0d rslts=%0d want %0d %0d %0d",
                     u, stalls, reqs, rslts, j + 1, j, h + 1);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ack_i   = '0;
        stall_i = 1'b0;
        #1;
        n_tests++;
        if ({stall_o, req_o, rslt_o, op1_o} !== {1'b0, NU'(0), 32'h0, a}) begin
            n_fail++;
            $display("FAIL idle_after u=%0d: got stall=%0b req=%b rslt=%h op1=%h want 0 0 0 %h",
                     u, stall_o, req_o, rslt_o, op1_o, a);
        end
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        stall_i    = 1'b0;
        valid_i    = 1'b0;
        cfu_ctrl_i = '0;
        src1_i     = '0;
        src2_i     = '0;
        ack_i      = '0;
        urslt_i    = '0;
        exp_err    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({stall_o, req_o, rslt_o, err_o, funct7_o, op1_o, op2_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: got stall=%0b req=%b rslt=%h err=%0b f7=%h op1=%h op2=%h want all 0",
                     stall_o, req_o, rslt_o, err_o, funct7_o, op1_o, op2_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_fast_ack();
        run_cmd(1, 32'd5, 32'd7, 7'h11, 1, 32'd12, 0, '0);
    endtask

    task automatic test_slow_ack_stall();
        run_cmd(3, $urandom, $urandom, 7'h3C, 10, 32'hA5A5A5A5, 3, '0);
    endtask

    task automatic test_illegal();
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            valid_i    = 1'b1;
            cfu_ctrl_i = {7'($urandom), 3'($urandom_range(NU, 7)), 1'b1};
            if (n == 5) cfu_ctrl_i = {7'h01, 3'd6, 1'b1};
            if (n == 4) cfu_ctrl_i = {7'h01, 3'd2, 1'b0};
            stall_i = 1'($urandom_range(0, 1));
            #1;
            n_tests++;
            if ({stall_o, req_o, rslt_o} !== {1'b0, NU'(0), 32'h0}) begin
                n_fail++;
                $display("FAIL illegal ctrl=%h: got stall=%0b req=%b rslt=%h want 0 0 0",
                         cfu_ctrl_i, stall_o, req_o, rslt_o);
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        stall_i = 1'b0;
        #1;
        n_tests++;
        if ({stall_o, req_o} !== {1'b0, NU'(0)}) begin
            n_fail++;
            $display("FAIL illegal_after: got stall=%0b req=%b want 0 0", stall_o, req_o);
        end
    endtask

    task automatic test_wrong_unit_ack();
        run_cmd(2, $urandom, $urandom, 7'h55, 5, $urandom, 1, 4'b0001);
    endtask

`ifdef CFU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        valid_i    = 1'b1;
        cfu_ctrl_i = {7'h22, 3'd2, 1'b1};
        src1_i     = $urandom;
        src2_i     = $urandom;
        ack_i      = '0;
        #1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            ack_i = 4'b1011;
            #1;
            n_tests++;
            if ({stall_o, req_o, err_o} !== {1'b1, 4'b0100, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_wait cyc=%0d: got stall=%0b req=%b err=%0b want 1 0100 0",
                         i, stall_o, req_o, err_o);
            end
        end
        @(negedge clk);
        ack_i = '0;
        #1;
        n_tests++;
        if ({stall_o, req_o, rslt_o, err_o} !== {1'b0, NU'(0), 32'hDEADBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_done: got stall=%0b req=%b rslt=%h err=%0b want 0 0 deadbeef 1",
                     stall_o, req_o, rslt_o, err_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        exp_err = 1'b1;
        run_cmd(0, $urandom, $urandom, 7'h09, 3, $urandom, 0, '0);
    endtask
`endif

    task automatic test_back_to_back();
        for (int n = 0; n < 25; n++) begin
            run_cmd(int'($urandom_range(0, NU - 1)), $urandom, $urandom, 7'($urandom),
                    int'($urandom_range(1, 6)), $urandom, int'($urandom_range(0, 3)),
                    NU'($urandom));
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        valid_i    = 1'b1;
        cfu_ctrl_i = {7'h7F, 3'd1, 1'b1};
        src1_i     = $urandom | 32'h1;
        src2_i     = $urandom | 32'h1;
        ack_i      = '0;
        repeat (3) @(negedge clk);
        #2;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        exp_err = 1'b0;
        #1;
        n_tests++;
        if ({stall_o, req_o, rslt_o, err_o, funct7_o, op1_o, op2_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got stall=%0b req=%b rslt=%h err=%0b f7=%h op1=%h op2=%h want all 0",
                     stall_o, req_o, rslt_o, err_o, funct7_o, op1_o, op2_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        run_cmd(1, $urandom, $urandom, 7'h2A, 2, $urandom, 1, '0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_fast_ack();
        test_slow_ack_stall();
        test_illegal();
        test_wrong_unit_ack();
`ifdef CFU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_seq.md
# cfu_seq

Sequencer sitting between the core's execute stage and a bank of multi-cycle CFU functional units. It decodes each CFU instruction, issues it to the unit selected by funct3 over a req/ack handshake, and stalls the pipeline until the unit answers. It then holds the result for the pipeline, honouring downstream stalls. Only one command is in flight at a time; the block owns all CFU-side stall generation.

## Interface

**Parameters**
- `NUM_UNITS`, default 4: number of attached units, 1..8; funct3 indexes them.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `CFU_SEQ_TIMEOUT_EN`.

**Ports**
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: downstream pipeline stall.
- `valid_i` in 1: instruction valid in execute.
- `cfu_ctrl_i` in `CFU_CTRL_WIDTH`: bit `CFU_CTRL_IS_CFU`; [3:1] funct3; [10:4] funct7.
- `src1_i`, `src2_i` in `XLEN`: operands.
- `stall_o` out 1: pipeline stall request.
- `rslt_o` out `XLEN`: result to writeback.
- `req_o` out `NUM_UNITS`: one-hot unit request.
- `funct7_o` out 7: latched funct7.
- `op1_o`, `op2_o` out `XLEN`: latched operands.
- `ack_i` in `NUM_UNITS`: unit completion, one cycle.
- `urslt_i` in `NUM_UNITS*XLEN`: unit results; unit k occupies [k*XLEN +: XLEN].
- `err_o` out 1: sticky timeout flag.

## Operation

**Command acceptance**
- `cmd = valid_i & cfu_ctrl_i[CFU_CTRL_IS_CFU]`.
- Legal command: `funct3 < NUM_UNITS`.
- Illegal command: no issue, no stall, `rslt_o` = 0 combinationally in the same cycle.

**States**
- IDLE: on a legal `cmd`, latch `funct3`, `funct7`, `src1`, `src2`, then go to WAIT.
- WAIT:
  - `req_o[u]` is held high until `ack_i[u]`.
  - On `ack_i[u]`: capture `urslt_i[u]`, drop `req_o` in the next cycle, go to DONE.
  - `ack_i` bits for other units are ignored.
- DONE:
  - `rslt_o` holds the captured value.
  - `stall_o` is low.
  - Go to IDLE when `stall_i` is low. Stay in DONE while `stall_i` is high.
  - No re-issue while in DONE, even though `valid_i` still presents the same instruction.

**stall_o**
- High in IDLE when a legal `cmd` is present (combinational, same cycle).
- High throughout WAIT.
- Low otherwise.

**Outputs**
- `rslt_o` outside DONE is 0.
- `op1_o`, `op2_o`, `funct7_o` are stable from the first WAIT cycle until the next accept.

**Reset**
- Asynchronous assertion at any time, including mid-WAIT, forces IDLE.
- Reset values: `req_o` = 0, `stall_o` = 0, `rslt_o` = 0, `err_o` = 0, latches = 0.
- A unit left mid-operation must tolerate `req_o` dropping.

## Timing

- Cycle 0: legal `cmd` in IDLE. `stall_o` = 1.
- Cycle 1: WAIT, `req_o` = 1.
- An ack in cycle n gives DONE in cycle n+1 with `stall_o` = 0 and a valid `rslt_o`.
- Minimum latency, with ack in cycle 1: result in cycle 2, so 2 stall cycles.
- `ack_i` coincident with the first `req_o` cycle is legal.
- `stall_i` high in IDLE with `cmd`: acceptance proceeds. The pipeline is frozen anyway.
- A `cmd` arriving while not in IDLE is ignored.

## Configuration

**`CFU_SEQ_TIMEOUT_EN` defined**
- A WAIT-cycle counter starts at 0 on entry to WAIT.
- When it reaches `TIMEOUT_CYCLES` without an ack:
  - drop `req_o`;
  - go to DONE with `rslt_o` = 32'hDEADBEEF;
  - set `err_o`, which stays set until reset.
- An ack in the same cycle as the timeout wins: normal result, no error.

**`CFU_SEQ_TIMEOUT_EN` not defined**
- WAIT lasts indefinitely.
- `err_o` is tied to 0.
- No counter logic is synthesized.

## Structure

- Shared constants stay in `config.vh`: `CFU_CTRL_WIDTH`, `CFU_CTRL_IS_CFU`, `XLEN`.
- New in `config.vh`:
  - state encodings `CFU_SEQ_IDLE`, `CFU_SEQ_WAIT`, `CFU_SEQ_DONE` (2 bits);
  - `CFU_SEQ_TIMEOUT_VAL` = 32'hDEADBEEF.
- One sub-module, `cfu_seq_watchdog`:
  - inputs: `clk_i`, `rst_ni`, `start`, `clear`; output: `expired`;
  - instantiated only under `CFU_SEQ_TIMEOUT_EN`.
- Result mux and one-hot request decode stay inline.

## Test plan

- **Fast ack:** funct3 = 1, src1 = 5, src2 = 7, unit 1 acks on its first req cycle with 12. Expect `stall_o` high for 2 cycles, `rslt_o` = 12 in cycle 2, `req_o` = 4'b0010 for exactly 1 cycle.
- **Slow ack with downstream stall:** unit 3 acks after 10 cycles with 32'hA5A5A5A5; `stall_i` high for 3 cycles in DONE. Expect `rslt_o` held for 4 cycles, then return to IDLE with no re-issue.
- **Illegal funct3:** `NUM_UNITS` = 4, funct3 = 6. Expect `stall_o` = 0, `rslt_o` = 0, `req_o` = 0.
- **Reset mid-operation:** `rst_ni` low in cycle 3 of WAIT. Expect all outputs 0 immediately (asynchronous), then IDLE. The next command completes normally.
- **Wrong-unit ack:** unit 0 acks while unit 2 is selected. Expect the ack ignored and the block still in WAIT.
- **Timeout (`CFU_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8):** no ack. Expect `rslt_o` = 32'hDEADBEEF and `err_o` = 1 after 8 WAIT cycles; `err_o` remains 1 across the next successful command.
